// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// multi-cycle mul/div EX holds, plus a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             ex_md_start,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_r,
  output logic             idex_r,
  output logic             exmem_r,
  output logic             memwb_r,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  // The start cycle itself is spent in RUN, hence the offset of two.
  localparam logic [3:0] MD_INIT = 4'(MD_LAT - 2);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [3:0]       md_cnt_r;
  logic [3:0]       md_cnt_nxt_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             load_use_s;
  logic             pc_en_s;
  logic             ifid_en_s;
  logic             idex_en_s;
  logic             exmem_en_s;
  logic             memwb_en_s;
  logic             ifid_r_s;
  logic             idex_r_s;
  logic             exmem_r_s;
  logic             memwb_r_s;

  assign load_use_s = ex_memread && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (ex_rd == id_rs1)) ||
                       (id_use_rs2 && (ex_rd == id_rs2)));

  // Next-state and pipeline enable/clear decode.
  always_comb begin
    state_nxt_s  = state_r;
    md_cnt_nxt_s = md_cnt_r;
    pc_en_s      = 1'b1;
    ifid_en_s    = 1'b1;
    idex_en_s    = 1'b1;
    exmem_en_s   = 1'b1;
    memwb_en_s   = 1'b1;
    ifid_r_s     = 1'b0;
    idex_r_s     = 1'b0;
    exmem_r_s    = 1'b0;
    memwb_r_s    = 1'b0;
    if (!rst_n) begin
      pc_en_s    = 1'b0;
      ifid_en_s  = 1'b0;
      idex_en_s  = 1'b0;
      exmem_en_s = 1'b0;
      memwb_en_s = 1'b0;
      ifid_r_s   = 1'b1;
      idex_r_s   = 1'b1;
      exmem_r_s  = 1'b1;
      memwb_r_s  = 1'b1;
    end else begin
      case (state_r)
        RUN: begin
          if (ex_md_start) begin
            pc_en_s      = 1'b0;
            ifid_en_s    = 1'b0;
            idex_en_s    = 1'b0;
            exmem_en_s   = 1'b0;
            exmem_r_s    = 1'b1;
            state_nxt_s  = MD_BUSY;
            md_cnt_nxt_s = MD_INIT;
          end else if (ex_branch_taken) begin
            ifid_r_s = 1'b1;
            idex_r_s = 1'b1;
          end else if (load_use_s) begin
            pc_en_s   = 1'b0;
            ifid_en_s = 1'b0;
            idex_r_s  = 1'b1;
          end else begin
            state_nxt_s = RUN;
          end
        end
        MD_BUSY: begin
          // Branch/start inputs are stale while EX is held, so they are ignored.
          if (md_cnt_r != 4'd0) begin
            pc_en_s      = 1'b0;
            ifid_en_s    = 1'b0;
            idex_en_s    = 1'b0;
            exmem_en_s   = 1'b0;
            exmem_r_s    = 1'b1;
            md_cnt_nxt_s = md_cnt_r - 4'd1;
          end else begin
            state_nxt_s = RUN;
          end
        end
        default: begin
          state_nxt_s  = RUN;
          md_cnt_nxt_s = 4'd0;
        end
      endcase
    end
  end

  // State and mul/div countdown registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= RUN;
      md_cnt_r <= 4'd0;
    end else begin
      state_r  <= state_nxt_s;
      md_cnt_r <= md_cnt_nxt_s;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (!pc_en_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign pc_en     = pc_en_s;
  assign ifid_en   = ifid_en_s;
  assign idex_en   = idex_en_s;
  assign exmem_en  = exmem_en_s;
  assign memwb_en  = memwb_en_s;
  assign ifid_r    = ifid_r_s;
  assign idex_r    = idex_r_s;
  assign exmem_r   = exmem_r_s;
  assign memwb_r   = memwb_r_s;
  assign md_busy   = (state_r == MD_BUSY);
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (MD_LAT=4, CNT_W=4 build).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_memread, ex_branch_taken, ex_md_start;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_r, idex_r, exmem_r, memwb_r, md_busy;
  logic [3:0] stall_cnt;

  typedef struct packed {
    logic [9:0] vec;
    logic [3:0] stall;
  } sb_t;

  sb_t        sb_q[$];
  logic [3:0] stall_model;
  int         checks = 0;
  int         errors = 0;
  logic [9:0] obs_vec;

  // {pc,ifid,idex,exmem,memwb enables | ifid,idex,exmem,memwb clears | md_busy}
  localparam logic [9:0] V_RUN = 10'b11111_0000_0;
  localparam logic [9:0] V_LU  = 10'b00111_0100_0;
  localparam logic [9:0] V_BR  = 10'b11111_1100_0;
  localparam logic [9:0] V_MDS = 10'b00001_0010_0;
  localparam logic [9:0] V_MDB = 10'b00001_0010_1;
  localparam logic [9:0] V_MDR = 10'b11111_0000_1;
  localparam logic [9:0] V_RST = 10'b00000_1111_0;

  always #5 clk = ~clk;

  assign obs_vec = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                    ifid_r, idex_r, exmem_r, memwb_r, md_busy};

  hazard_ctrl #(.MD_LAT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_r(ifid_r), .idex_r(idex_r), .exmem_r(exmem_r), .memwb_r(memwb_r),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  task automatic step(input string tag, input logic rst, input logic mr,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic br,
                      input logic md, input logic [9:0] exp);
    sb_t e;
    sb_t got;
    @(negedge clk);
    rst_n = rst;  ex_memread = mr;  ex_rd = rd;
    id_rs1 = rs1; id_use_rs1 = u1;  id_rs2 = rs2; id_use_rs2 = u2;
    ex_branch_taken = br; ex_md_start = md;
    if (!rst) stall_model = 4'd0;
    e.vec   = exp;
    e.stall = stall_model;
    sb_q.push_back(e);
    if (rst && !exp[9] && (stall_model != 4'hF)) stall_model = stall_model + 4'd1;
    #1;
    got = sb_q.pop_front();
    checks++;
    assert (obs_vec === got.vec) else begin
      errors++;
      $error("FAIL %s outputs observed=%b expected=%b", tag, obs_vec, got.vec);
    end
    checks++;
    assert (stall_cnt === got.stall) else begin
      errors++;
      $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, stall_cnt, got.stall);
    end
  endtask

  task automatic idle(input string tag, input logic [9:0] exp);
    step(tag, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, exp);
  endtask

  initial begin
    rst_n = 1'b0; stall_model = 4'd0;
    ex_memread = 1'b0; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_branch_taken = 1'b0; ex_md_start = 1'b0;

    step("reset0", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, V_RST);
    step("reset1", 1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, V_RST);
    idle("first_run", V_RUN);

    step("lu_rs2", 1'b1, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, V_LU);
    idle("after_lu", V_RUN);
    step("lu_x0", 1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, V_RUN);
    step("lu_unused", 1'b1, 1'b1, 5'd7, 5'd7, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, V_RUN);
    step("lu_rs1", 1'b1, 1'b1, 5'd9, 5'd9, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, V_LU);
    step("no_load", 1'b1, 1'b0, 5'd9, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, V_RUN);

    step("br_lu", 1'b1, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, V_BR);
    idle("after_br", V_RUN);

    step("md_start_br", 1'b1, 1'b1, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, V_MDS);
    step("md_busy1", 1'b1, 1'b1, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, V_MDB);
    idle("md_busy2", V_MDB);
    idle("md_release", V_MDR);
    idle("md_after", V_RUN);

    step("md_start2", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, V_MDS);
    step("md_br_ign", 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, V_MDB);
    step("md_abort", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, V_RST);
    idle("abort_rel", V_RUN);
    idle("abort_run", V_RUN);

    for (int i = 0; i < 21; i++)
      step("sat_lu", 1'b1, 1'b1, 5'd12, 5'd12, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, V_LU);
    idle("sat_hold", V_RUN);
    idle("sat_hold2", V_RUN);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MD_LAT, default 4, giving the multi-cycle (mul/div) EX latency in cycles; legal range 2..15.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the stall-counter width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-006 id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2.
REQ-007 ex_memread  in  1  EX instruction is a load.
REQ-008 ex_rd  in  5  destination register of the EX instruction.
REQ-009 ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle.
REQ-010 ex_md_start  in  1  EX holds a new mul/div instruction this cycle.
REQ-011 pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  load enables for the PC and the four pipeline registers.
REQ-012 ifid_r, idex_r, exmem_r, memwb_r  out  1 each  synchronous clear (bubble insert) for the four pipeline registers.
REQ-013 md_busy  out  1  multi-cycle op in progress.
REQ-014 stall_cnt  out  CNT_W  cycles in which pc_en was 0.

Function
REQ-015 The block SHALL implement states RUN and MD_BUSY plus a 4-bit down-counter md_cnt.
REQ-016 Load-use hazard: ex_memread=1, ex_rd!=0, and (ex_rd==id_rs1 with id_use_rs1=1, or ex_rd==id_rs2 with id_use_rs2=1).
REQ-017 RUN, no events: all enables 1, all clears 0.
REQ-018 RUN, load-use hazard only: pc_en=0, ifid_en=0, idex_r=1; other enables 1; one bubble per hazard cycle.
REQ-019 RUN, ex_branch_taken=1: ifid_r=1, idex_r=1, pc_en=1; load-use is ignored that cycle (branch priority).
REQ-020 RUN, ex_md_start=1 (with or without branch): same cycle pc_en=ifid_en=idex_en=exmem_en=0, exmem_r=1, memwb_en=1; next state MD_BUSY, md_cnt<=MD_LAT-2.
REQ-021 ex_md_start takes priority over ex_branch_taken and load-use in RUN; branch is re-presented by EX after release.
REQ-022 MD_BUSY, md_cnt!=0: outputs as in REQ-020; md_cnt decrements; ex_branch_taken and ex_md_start are ignored.
REQ-023 MD_BUSY, md_cnt==0: all enables 1, all clears 0 (EX result captured into EX/MEM); next state RUN.
REQ-024 Result: total EX occupancy of a mul/div = MD_LAT cycles; exactly MD_LAT-1 bubbles enter EX/MEM.
REQ-025 md_busy SHALL be 1 exactly while state==MD_BUSY.
REQ-026 stall_cnt SHALL increment each cycle pc_en==0 and saturate at all-ones (no wrap).
REQ-027 Enable/clear outputs are combinational from state, md_cnt and inputs; state, md_cnt, stall_cnt are registers.

Reset
REQ-028 rst_n=0 SHALL immediately, without a clock: state=RUN, md_cnt=0, stall_cnt=0.
REQ-029 While rst_n=0: all enables 0, all clears (ifid_r, idex_r, exmem_r, memwb_r) 1, md_busy=0.
REQ-030 Reset asserted mid-MD_BUSY SHALL abort the op; after release the block is in RUN with no residual stall.
REQ-031 First cycle after rst_n rises with no events: REQ-017 outputs.

Verification
REQ-032 Load-use: ex_memread=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for 1 cycle -> pc_en=0, ifid_en=0, idex_r=1 that cycle; stall_cnt 0->1.
REQ-033 x0 / unused operand: ex_memread=1, ex_rd=0, id_rs1=0 (or ex_rd=7, id_rs1=7, id_use_rs1=0) -> no stall, all enables 1.
REQ-034 Branch+load-use same cycle -> ifid_r=1, idex_r=1, pc_en=1, stall_cnt unchanged.
REQ-035 MD_LAT=4, ex_md_start pulse -> md_busy 1 for 3 cycles, exmem_r=1 for 3 cycles, then exmem_en=1 once; stall_cnt +3.
REQ-036 ex_branch_taken=1 during MD_BUSY -> no flush; rst_n=0 in 2nd busy cycle -> immediate RUN, md_busy=0, stall_cnt=0, all clears 1.
REQ-037 stall_cnt forced by 2^CNT_W+5 stall cycles (CNT_W=4 build: 21) -> holds at 15.
